// File: rtl/alu_result_buffer.sv
// alu_result_buffer: first-word fall-through FIFO that holds ALU results (z, ex, op)
// between the ALU and its consumer. It also keeps a sticky flag that records
// whether any accepted result had ex=1.
// Optional feature: define ALU_RESULT_ZERO_FLAG_EN to add the out_zero output,
// which is high when the head entry is valid and its z is zero.
module alu_result_buffer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_z,
  input  logic                     in_ex,
  input  logic [2:0]               in_op,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_z,
  output logic                     out_ex,
  output logic [2:0]               out_op,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
`ifdef ALU_RESULT_ZERO_FLAG_EN
  output logic                     out_zero,
`endif
  output logic                     ex_seen
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef struct packed {
    logic [WIDTH-1:0] z;
    logic             ex;
    logic [2:0]       op;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          head;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            ex_seen_q, ex_seen_d;
  logic            push, pop;

  // Advance a pointer, wrapping from DEPTH-1 back to 0.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(DEPTH - 1)) begin
      return '0;
    end
    return p + PtrW'(1);
  endfunction

  // Handshake flags; both derive from registered occupancy only, so no
  // combinational path runs from in_valid/out_ready to the ready/valid outputs.
  always_comb begin
    in_ready  = (count_q < CntW'(DEPTH));
    out_valid = (count_q != '0);
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
  end

  // Next-state for pointers, occupancy and the sticky ex flag; flush wins over push/pop.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ex_seen_d = ex_seen_q;
    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      ex_seen_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
        if (in_ex) begin
          ex_seen_d = 1'b1;
        end
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ex_seen_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ex_seen_q <= ex_seen_d;
    end
  end

  // Entry storage; not reset because the head outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q] <= '{z: in_z, ex: in_ex, op: in_op};
    end
  end

  // Head fields straight from storage, forced to zero when nothing is valid.
  always_comb begin
    head   = mem_q[rd_ptr_q];
    out_z  = '0;
    out_ex = 1'b0;
    out_op = 3'b000;
    if (out_valid) begin
      out_z  = head.z;
      out_ex = head.ex;
      out_op = head.op;
    end
  end

  assign count   = count_q;
  assign ex_seen = ex_seen_q;

`ifdef ALU_RESULT_ZERO_FLAG_EN
  // out_z is already zero when empty, so the out_valid term is what matters.
  assign out_zero = out_valid && (out_z == '0);
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
// Scoreboard bench for alu_result_buffer: directed stimulus pushes expected
// entries into a queue, a negedge monitor pops and compares on each handshake.
module tb_alu_result_buffer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_z;
  logic        in_ex;
  logic [2:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_z;
  logic        out_ex;
  logic [2:0]  out_op;
  logic        flush;
  logic [2:0]  count;
  logic        ex_seen;
`ifdef ALU_RESULT_ZERO_FLAG_EN
  logic        out_zero;
`endif

  typedef struct {
    logic [31:0] z;
    logic        ex;
    logic [2:0]  op;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  alu_result_buffer #(.WIDTH(32), .DEPTH(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_z      (in_z),
    .in_ex     (in_ex),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_z     (out_z),
    .out_ex    (out_ex),
    .out_op    (out_op),
    .flush     (flush),
    .count     (count),
`ifdef ALU_RESULT_ZERO_FLAG_EN
    .out_zero  (out_zero),
`endif
    .ex_seen   (ex_seen)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge; acc marks an entry
  // that the hand-worked schedule says will be accepted at the next edge.
  task automatic drive(input bit v, input logic [31:0] z, input bit ex, input logic [2:0] op,
                       input bit rdy, input bit fl, input bit acc);
    exp_t e;
    @(posedge clk);
    #1;
    in_valid  = v;
    in_z      = z;
    in_ex     = ex;
    in_op     = op;
    out_ready = rdy;
    flush     = fl;
    if (fl) exp_q.delete();
    if (acc) begin
      e.z  = z;
      e.ex = ex;
      e.op = op;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input bit rdy);
    drive(1'b0, 32'h0, 1'b0, 3'b000, rdy, 1'b0, 1'b0);
  endtask

  task automatic state(input string tag, input int c, input bit ir, input bit ov, input bit es);
    @(negedge clk);
    chk({tag, "_count"}, 32'(count), 32'(c));
    chk({tag, "_in_ready"}, 32'(in_ready), 32'(ir));
    chk({tag, "_out_valid"}, 32'(out_valid), 32'(ov));
    chk({tag, "_ex_seen"}, 32'(ex_seen), 32'(es));
  endtask

  // Monitor: compares the head against the scoreboard whenever a pop will occur.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && !flush) begin
      if (!out_valid) begin
        chk("mask_z", out_z, 32'h0);
        chk("mask_ex_op", {28'h0, out_ex, out_op}, 32'h0);
`ifdef ALU_RESULT_ZERO_FLAG_EN
        chk("mask_zero", 32'(out_zero), 32'h0);
`endif
      end else if (out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop: got z=%0h expected no entry at %0t", out_z, $time);
        end else begin
          e = exp_q.pop_front();
          chk("pop_z", out_z, e.z);
          chk("pop_ex", 32'(out_ex), 32'(e.ex));
          chk("pop_op", 32'(out_op), 32'(e.op));
`ifdef ALU_RESULT_ZERO_FLAG_EN
          chk("pop_zero", 32'(out_zero), 32'(e.z == 32'h0));
`endif
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish by 100000");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_z      = 32'h0;
    in_ex     = 1'b0;
    in_op     = 3'b000;
    out_ready = 1'b0;
    flush     = 1'b0;
    #3;
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_ex_seen", 32'(ex_seen), 32'h0);
    chk("rst_out_z", out_z, 32'h0);
    #9;
    reset_n = 1'b1;

    // Single push, visible one edge later.
    drive(1'b1, 32'h0000000F, 1'b0, 3'b010, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    state("single", 1, 1'b1, 1'b1, 1'b0);
    chk("single_z", out_z, 32'h0000000F);
    chk("single_op", 32'(out_op), 32'h2);
    idle(1'b1);
    idle(1'b0);
    state("single_drain", 0, 1'b1, 1'b0, 1'b0);

    // Fill to DEPTH; fifth push must be refused.
    drive(1'b1, 32'd1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 32'd2, 1'b0, 3'b001, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 32'd3, 1'b0, 3'b010, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 32'd4, 1'b0, 3'b110, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 32'd5, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0);
    state("full", 4, 1'b0, 1'b1, 1'b0);
    // Full with push+pop: only the pop happens.
    drive(1'b1, 32'd6, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    state("full_pushpop", 3, 1'b1, 1'b1, 1'b0);
    // Push+pop at count 3: count holds, write pointer wraps to 0.
    drive(1'b1, 32'd7, 1'b0, 3'b111, 1'b1, 1'b0, 1'b1);
    idle(1'b0);
    state("pushpop3", 3, 1'b1, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);
    state("drained", 0, 1'b1, 1'b0, 1'b0);

    // out_ready while empty has no effect.
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);
    state("empty_pop", 0, 1'b1, 1'b0, 1'b0);

    // ex sets the sticky flag; flush with a push discards everything.
    drive(1'b1, 32'h80000000, 1'b1, 3'b110, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    state("ex_set", 1, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 32'h00000055, 1'b0, 3'b010, 1'b1, 1'b1, 1'b0);
    idle(1'b0);
    state("flush", 0, 1'b1, 1'b0, 1'b0);
    chk("flush_z", out_z, 32'h0);
    chk("flush_ex_op", {28'h0, out_ex, out_op}, 32'h0);

    // Asynchronous reset between edges with two entries held.
    drive(1'b1, 32'h000000A1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 32'h000000B2, 1'b1, 3'b001, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    state("pre_reset", 2, 1'b1, 1'b1, 1'b1);
    #1;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk("async_count", 32'(count), 32'h0);
    chk("async_out_valid", 32'(out_valid), 32'h0);
    chk("async_in_ready", 32'(in_ready), 32'h1);
    chk("async_ex_seen", 32'(ex_seen), 32'h0);
    #1;
    reset_n = 1'b1;
    idle(1'b1);
    state("post_reset", 0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'h00000009, 1'b0, 3'b001, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b0);
    state("post_reset_drain", 0, 1'b1, 1'b0, 1'b0);

    // Zero result followed by a non-zero one (zero flag checked by the monitor when enabled).
    drive(1'b1, 32'h00000000, 1'b0, 3'b111, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 32'h00000001, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    state("zero_pair", 2, 1'b1, 1'b1, 1'b0);
`ifdef ALU_RESULT_ZERO_FLAG_EN
    chk("zero_head", 32'(out_zero), 32'h1);
`endif
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);
    state("zero_drain", 0, 1'b1, 1'b0, 1'b0);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left: got %0d entries expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_result_buffer.md
ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

Interface
REQ-001 Parameter WIDTH, default 32, data width of the ALU result.
REQ-002 Parameter DEPTH, default 4, entry count; power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  ALU result presented for capture.
REQ-006 in_ready  output  1  buffer can accept an entry this cycle.
REQ-007 in_z  input  WIDTH  ALU result z.
REQ-008 in_ex  input  1  ALU ex (overflow/exception) bit.
REQ-009 in_op  input  3  ALU op that produced z (000 and, 001 or, 010 add, 110 sub, 111 slt).
REQ-010 out_valid  output  1  head entry available.
REQ-011 out_ready  input  1  consumer takes the head entry.
REQ-012 out_z / out_ex / out_op  output  WIDTH / 1 / 3  head entry fields.
REQ-013 flush  input  1  synchronous discard of all entries.
REQ-014 count  output  clog2(DEPTH)+1  current occupancy.
REQ-015 ex_seen  output  1  sticky flag: an accepted entry had ex=1.

Function
REQ-016 The block SHALL be a FIFO: push when in_valid and in_ready; pop when out_valid and out_ready.
REQ-017 in_ready SHALL equal (count < DEPTH), derived from registered state only.
REQ-018 out_valid SHALL equal (count != 0); head fields SHALL be driven from storage (first-word fall-through).
REQ-019 When out_valid=0, out_z, out_ex and out_op SHALL be driven to 0.
REQ-020 Latency: an entry accepted at edge N SHALL be visible with out_valid=1 after edge N; no same-cycle bypass.
REQ-021 Push and pop in the same cycle SHALL leave count unchanged and advance both pointers.
REQ-022 When full, in_ready=0 and a same-cycle pop SHALL NOT admit a push.
REQ-023 When empty, out_ready SHALL have no effect.
REQ-024 Read and write pointers SHALL wrap from DEPTH-1 to 0.
REQ-025 Entries SHALL leave in acceptance order, with z, ex and op unmodified.
REQ-026 ex_seen SHALL set on the edge that accepts an entry with in_ex=1, and hold until flush or reset.
REQ-027 flush SHALL, on the next edge, zero count and both pointers and clear ex_seen, taking priority over a same-cycle push or pop.
REQ-028 A handshake is one-way committed: the producer holds in_z/in_ex/in_op stable while in_valid=1 and in_ready=0.

Reset
REQ-029 reset_n low SHALL immediately force count=0, pointers=0, ex_seen=0, out_valid=0 and in_ready=1, independent of clk.
REQ-030 Reset asserted mid-transfer SHALL discard all entries; the first edge after release SHALL behave as empty.
REQ-031 Storage contents need no reset, since outputs are masked by REQ-019.

Configuration
REQ-032 Macro ALU_RESULT_ZERO_FLAG_EN: when defined, the block SHALL add output out_zero (1 bit), equal to 1 when out_valid=1 and out_z==0, else 0.
REQ-033 When ALU_RESULT_ZERO_FLAG_EN is undefined, out_zero SHALL be absent from the port list, and all other behaviour SHALL be identical.

Verification
REQ-034 Reset, then push z=0x0000000F, op=010, ex=0 -> out_valid=1 one edge later with out_z=0x0000000F, out_op=010, count=1.
REQ-035 Four pushes with out_ready=0 (z=1,2,3,4) -> count=4, in_ready=0; fifth push ignored; then drain -> outputs 1,2,3,4 in order, count=0.
REQ-036 Full, with push and pop asserted together -> only the pop occurs, count=3; then push+pop with count=3 -> count stays 3 and pointers wrap correctly.
REQ-037 Push ex=1, op=110, then flush asserted together with a push -> next edge count=0, ex_seen=0, out_valid=0, out_z=0.
REQ-038 reset_n pulsed low between edges with 2 entries held -> count=0 and out_valid=0 immediately, before any clk edge.
REQ-039 With ALU_RESULT_ZERO_FLAG_EN defined, push z=0, op=111 -> out_zero=1; push z=1 -> out_zero=0 once that entry reaches head.
